chunk_serial_adder: RTL and testbench
=====================================

// Module: chunk_serial_adder
//
// PURPOSE
// Parametrised multi-cycle adder, successor to the single-bit full adder.
// Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, over a
// ripple chain of CHUNK full adders, and carries between chunks in a register.
// Uses valid/ready handshakes on input and output.
// Trades latency for area in datapaths where a full-width adder is too large.
//
// PARAMETERS
// WIDTH  16  operand/sum width in bits; >= 1
// CHUNK  4   bits added per cycle; 1 <= CHUNK <= WIDTH, WIDTH % CHUNK == 0
//
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      asynchronous reset, active-high
// in_valid   in   1      a/b/cin valid
// in_ready   out  1      block can accept operands
// a          in   WIDTH  operand A, unsigned or two's complement
// b          in   WIDTH  operand B
// cin        in   1      carry-in
// out_valid  out  1      sum/cout/overflow valid
// out_ready  in   1      consumer accepts result
// sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
// cout       out  1      carry out of bit WIDTH-1 (unsigned overflow)
// overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
// - NCHUNK = WIDTH/CHUNK. Chunk index counter width = max(1, clog2(NCHUNK)).
// - States:
//   - IDLE: in_ready=1, out_valid=0.
//   - RUN: in_ready=0, out_valid=0.
//   - DONE: in_ready=0, out_valid=1.
// - IDLE: on in_valid&&in_ready at an edge:
//   - latch a, b into operand registers;
//   - carry reg <= cin; idx <= 0; clear sum reg; go to RUN.
// - RUN, each edge: compute {c, s} = a[idx*CHUNK +: CHUNK] + b[idx chunk] + carry.
//   - sum[idx chunk] <= s; carry <= c.
//   - On the last chunk only, capture the carry into bit WIDTH-1 for overflow.
//   - idx == NCHUNK-1: cout <= c; overflow <= c_msb_in ^ c; go to DONE.
//     Otherwise idx <= idx+1.
// - Latency: operands accepted at edge k -> out_valid high after edge k+NCHUNK.
//   NCHUNK=1 gives a single-cycle result.
// - DONE: sum/cout/overflow held stable while out_valid && !out_ready.
//   On out_valid&&out_ready at an edge -> IDLE. Back-to-back accept is not
//   possible: in_ready rises the cycle after the handshake.
// - Throughput: one result per NCHUNK+2 cycles, with out_ready held high.
// - Inputs a/b/cin are sampled only on the accepting edge. Changes during
//   RUN/DONE are ignored.
// - Reset (asynchronous, any state, including mid-RUN): state=IDLE, idx=0,
//   carry=0, sum=0, cout=0, overflow=0, out_valid=0, in_ready=1 after reset
//   deasserts. Any partial result is discarded, no output is produced.
// - Outputs are registered; no combinational path from inputs to outputs
//   except in_ready, which is decoded from state only.
// - Sum is bit-exact modulo 2^WIDTH. All-ones + 1 wraps to 0 with cout=1.
//
// TESTING  (WIDTH=16, CHUNK=4 unless stated)
// 1. a=0x1234 b=0x4321 cin=1 -> after 4 cycles out_valid=1, sum=0x5556, cout=0, ovf=0.
// 2. a=0xFFFF b=0x0001 cin=0 -> sum=0x0000, cout=1, ovf=0 (wrap-around).
// 3. a=0x7FFF b=0x0001 cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000 b=0x8000 -> sum=0, cout=1, ovf=1.
// 4. out_ready low 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0; new
//    in_valid ignored until the cycle after the handshake.
// 5. rst pulsed mid-RUN (idx=2) -> outputs 0 immediately, in_ready=1 after
//    release; next op a=1 b=2 -> sum=3.
// 6. CHUNK=16: a=0xAAAA b=0x5555 cin=1 -> sum=0x0000, cout=1, out_valid one cycle after accept;
//    exhaustive random vs a+b+cin reference model.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in CHUNK bits per clock,
// carrying between chunks in a register, with valid/ready handshakes on both sides.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              overflow_q, overflow_d;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  s_chunk;
    logic [CHUNK:0]    chain;

    // Ripple chain of CHUNK full adders over the currently selected chunk.
    always_comb begin
        a_chunk  = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk  = b_q[idx_q*CHUNK +: CHUNK];
        chain    = '0;
        s_chunk  = '0;
        chain[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            s_chunk[i]   = a_chunk[i] ^ b_chunk[i] ^ chain[i];
            chain[i+1]   = (a_chunk[i] & b_chunk[i]) | (chain[i] & (a_chunk[i] ^ b_chunk[i]));
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = s_chunk;
                carry_d = chain[CHUNK];
                if (idx_q == LAST_IDX) begin
                    // chain[CHUNK-1] is the carry into the operand MSB on the last chunk
                    cout_d     = chain[CHUNK];
                    overflow_d = chain[CHUNK-1] ^ chain[CHUNK];
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: a 4-bit-chunk instance and a full-width
// (single-chunk) instance, each checked against hand-computed and modelled sums.
module tb_chunk_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, ovf4;
    logic [15:0] a4, b4, sum4;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    // Runs one operation on the CHUNK=4 instance; returns latency and result.
    task automatic op4(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       output int lat, output logic [15:0] s, output logic co, output logic ov);
        @(negedge clk);
        a4 = av; b4 = bv; cin4 = ci; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum4; co = cout4; ov = ovf4;
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        output int lat, output logic [15:0] s, output logic co, output logic ov);
        @(negedge clk);
        a16 = av; b16 = bv; cin16 = ci; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum16; co = cout16; ov = ovf16;
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; cin16 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready4, out_valid4);
        end
        checks++;
        if (sum4 !== 16'h0 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: sum=%h cout=%b ovf=%b, required 0000/0/0", sum4, cout4, ovf4);
        end
        checks++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || sum16 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_wide: in_ready=%b out_valid=%b sum=%h, required 1/0/0000", in_ready16, out_valid16, sum16);
        end
    endtask

    task automatic test_basic();
        int lat; logic [15:0] s; logic co, ov;
        op4(16'h1234, 16'h4321, 1'b1, lat, s, co, ov);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d cycles, required 4", lat);
        end
        checks++;
        if (s !== 16'h5556 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_sum: sum=%h cout=%b ovf=%b, required 5556/0/0", s, co, ov);
        end
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1/0", in_ready4, out_valid4);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [15:0] s; logic co, ov;
        op4(16'hFFFF, 16'h0001, 1'b0, lat, s, co, ov);
        checks++;
        if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap: sum=%h cout=%b ovf=%b, required 0000/1/0", s, co, ov);
        end
        op4(16'hFFFF, 16'hFFFF, 1'b1, lat, s, co, ov);
        checks++;
        if (s !== 16'hFFFF || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_all_ones: sum=%h cout=%b ovf=%b, required FFFF/1/0", s, co, ov);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [15:0] s; logic co, ov;
        op4(16'h7FFF, 16'h0001, 1'b0, lat, s, co, ov);
        checks++;
        if (s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_pos: sum=%h cout=%b ovf=%b, required 8000/0/1", s, co, ov);
        end
        op4(16'h8000, 16'h8000, 1'b0, lat, s, co, ov);
        checks++;
        if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_neg: sum=%h cout=%b ovf=%b, required 0000/1/1", s, co, ov);
        end
        op4(16'h8000, 16'h7FFF, 1'b1, lat, s, co, ov);
        checks++;
        if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_mixed: sum=%h cout=%b ovf=%b, required 0000/1/0", s, co, ov);
        end
    endtask

    // Result must hold while the consumer stalls; offered operands wait for IDLE.
    task automatic test_hold();
        int lat; logic [15:0] s; logic co, ov;
        @(negedge clk);
        a4 = 16'h00FF; b4 = 16'h0F0F; cin4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        a4 = 16'h0005; b4 = 16'h0006; cin4 = 1'b0; in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || sum4 !== 16'h100E || cout4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: out_valid=%b in_ready=%b sum=%h cout=%b, required 1/0/100E/0",
                         i, out_valid4, in_ready4, sum4, cout4);
            end
        end
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release: in_ready=%b out_valid=%b, required 1/0", in_ready4, out_valid4);
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || sum4 !== 16'h000B) begin
            errors++;
            $display("[TB] FAIL hold_next_op: lat=%0d sum=%h, required 4/000B", lat, sum4);
        end
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [15:0] s; logic co, ov;
        logic seen;
        @(negedge clk);
        a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid4 !== 1'b0 || sum4 !== 16'h0 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_outputs: out_valid=%b sum=%h cout=%b ovf=%b, required 0/0000/0/0",
                     out_valid4, sum4, cout4, ovf4);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_no_output: stray output or not ready after release, required idle");
        end
        op4(16'h0001, 16'h0002, 1'b0, lat, s, co, ov);
        checks++;
        if (s !== 16'h0003 || co !== 1'b0 || lat !== 4) begin
            errors++;
            $display("[TB] FAIL midrun_next_op: sum=%h cout=%b lat=%0d, required 0003/0/4", s, co, lat);
        end
    endtask

    // With both valid and ready held high, results appear every NCHUNK+2 cycles.
    task automatic test_back_to_back();
        int first, second, cyc;
        first = -1; second = -1;
        @(negedge clk);
        a4 = 16'h0101; b4 = 16'h0202; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
        for (cyc = 0; cyc < 20 && second < 0; cyc++) begin
            @(posedge clk); #1;
            if (out_valid4 === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        checks++;
        if (second - first !== 6 || first < 0) begin
            errors++;
            $display("[TB] FAIL throughput: result spacing %0d cycles, required 6", second - first);
        end
        while (!in_ready4 || out_valid4) begin
            @(posedge clk); #1;
        end
        out_ready4 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_chunk();
        int lat; logic [15:0] s; logic co, ov;
        op16(16'hAAAA, 16'h5555, 1'b1, lat, s, co, ov);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL wide_latency: got %0d cycles, required 1", lat);
        end
        checks++;
        if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wide_sum: sum=%h cout=%b ovf=%b, required 0000/1/0", s, co, ov);
        end
    endtask

    task automatic test_random();
        int lat; logic [15:0] s; logic co, ov;
        logic [15:0] av, bv; logic ci;
        logic [16:0] full; logic exp_ov;
        for (int n = 0; n < 24; n++) begin
            av = 16'($urandom); bv = 16'($urandom); ci = 1'($urandom);
            full = {1'b0, av} + {1'b0, bv} + {16'b0, ci};
            exp_ov = (av[15] == bv[15]) && (full[15] != av[15]);
            if (n % 2 == 0) op4(av, bv, ci, lat, s, co, ov);
            else            op16(av, bv, ci, lat, s, co, ov);
            checks++;
            if (s !== full[15:0] || co !== full[16] || ov !== exp_ov) begin
                errors++;
                $display("[TB] FAIL random%0d: %h+%h+%b gave sum=%h cout=%b ovf=%b, required %h/%b/%b",
                         n, av, bv, ci, s, co, ov, full[15:0], full[16], exp_ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_single_chunk();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
